// File: rtl/fwd_pkg.sv
// Shared types and the per-operand source-selection rule for the forwarding scoreboard.
//   REG_W      : register index width
//   fwd_src_e  : which producer an operand resolves to
//   fwd_select : priority compare of one source index against the in-flight producers
package fwd_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MC,
    SRC_EXMEM,
    SRC_MEMWB
  } fwd_src_e;

  // The in-flight MC result is the youngest producer, so it is checked first.
  // EX/MEM is checked next, then MEM/WB. Register 0 never forwards.
  function automatic fwd_src_e fwd_select(
    input logic [REG_W-1:0] rs,
    input logic             pend_v,
    input logic [REG_W-1:0] pend_rd,
    input logic             ex_mem_regwrite,
    input logic [REG_W-1:0] ex_mem_rd,
    input logic             mem_wb_regwrite,
    input logic [REG_W-1:0] mem_wb_rd
  );
    fwd_src_e src;
    src = SRC_NONE;
    if (rs == '0) begin
      src = SRC_NONE;
    end else if (pend_v && (pend_rd == rs)) begin
      src = SRC_MC;
    end else if (ex_mem_regwrite && (ex_mem_rd == rs)) begin
      src = SRC_EXMEM;
    end else if (mem_wb_regwrite && (mem_wb_rd == rs)) begin
      src = SRC_MEMWB;
    end
    return src;
  endfunction

endpackage

// File: rtl/fwd_lane.sv
// One source operand's forwarding resolution.
// Inputs : rs (operand index), scoreboard state (pend_v, pend_rd, mc_done, mc_result),
//          EX/MEM control and candidates, MEM/WB write-back.
// Outputs: flag (use data instead of register file), data, lane_stall (operand not ready).
module fwd_lane
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [REG_W-1:0] rs,
  input  logic             pend_v,
  input  logic [REG_W-1:0] pend_rd,
  input  logic             mc_done,
  input  logic [XLEN-1:0]  mc_result,
  input  logic             ex_mem_regwrite,
  input  logic             ex_mem_memread,
  input  logic             ex_mem_jump,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic [XLEN-1:0]  ex_mem_alu_result,
  input  logic [XLEN-1:0]  ex_mem_pc_step,
  input  logic             mem_wb_regwrite,
  input  logic [REG_W-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]  mem_wb_data,
  output logic             flag,
  output logic [XLEN-1:0]  data,
  output logic             lane_stall
);

  fwd_src_e src;

  always_comb begin
    src        = fwd_select(rs, pend_v, pend_rd, ex_mem_regwrite, ex_mem_rd,
                            mem_wb_regwrite, mem_wb_rd);
    flag       = 1'b0;
    data       = mem_wb_data;
    lane_stall = 1'b0;
    unique case (src)
      SRC_MC: begin
        if (mc_done) begin
          flag = 1'b1;
          data = mc_result;
        end else begin
          lane_stall = 1'b1;
        end
      end
      SRC_EXMEM: begin
        // Load data is not available until MEM/WB: load-use bubble.
        if (ex_mem_memread) begin
          lane_stall = 1'b1;
        end else begin
          flag = 1'b1;
          data = ex_mem_jump ? ex_mem_pc_step : ex_mem_alu_result;
        end
      end
      SRC_MEMWB: begin
        flag = 1'b1;
        data = mem_wb_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// EX-stage forwarding with load-use and multi-cycle-unit hazard handling.
// A one-entry scoreboard tracks the single in-flight MC op with a latency counter.
// Inputs : ID/EX operand/destination info, EX/MEM and MEM/WB forward candidates, mc_result.
// Outputs: fwd_flag/fwd_data per operand, stall (gates IF/ID and ID/EX),
//          mc_busy, mc_done (write mc_result at mc_pending_rd), mc_pending_rd.
module forwarding_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned MC_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ex_valid,
  input  logic [REG_W*NSRC-1:0] id_ex_rs,
  input  logic [REG_W-1:0]      id_ex_rd,
  input  logic                  id_ex_regwrite,
  input  logic                  id_ex_mc,
  input  logic                  ex_fire,
  input  logic                  ex_mem_regwrite,
  input  logic                  ex_mem_memread,
  input  logic                  ex_mem_jump,
  input  logic [REG_W-1:0]      ex_mem_rd,
  input  logic [XLEN-1:0]       ex_mem_alu_result,
  input  logic [XLEN-1:0]       ex_mem_pc_step,
  input  logic                  mem_wb_regwrite,
  input  logic [REG_W-1:0]      mem_wb_rd,
  input  logic [XLEN-1:0]       mem_wb_data,
  input  logic [XLEN-1:0]       mc_result,
  output logic [NSRC-1:0]       fwd_flag,
  output logic [XLEN*NSRC-1:0]  fwd_data,
  output logic                  stall,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [REG_W-1:0]      mc_pending_rd
);

  logic [3:0]       cnt_q, cnt_d;
  logic             pend_v_q, pend_v_d;
  logic [REG_W-1:0] pend_rd_q, pend_rd_d;
  logic [NSRC-1:0]  lane_stall;
  logic             struct_hz, waw_hz, issue;

  assign mc_busy       = (cnt_q != 4'd0);
  assign mc_done       = (cnt_q == 4'd1);
  assign mc_pending_rd = pend_rd_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_lane
    fwd_lane #(
      .XLEN(XLEN)
    ) u_lane (
      .rs               (id_ex_rs[REG_W*i +: REG_W]),
      .pend_v           (pend_v_q),
      .pend_rd          (pend_rd_q),
      .mc_done          (mc_done),
      .mc_result        (mc_result),
      .ex_mem_regwrite  (ex_mem_regwrite),
      .ex_mem_memread   (ex_mem_memread),
      .ex_mem_jump      (ex_mem_jump),
      .ex_mem_rd        (ex_mem_rd),
      .ex_mem_alu_result(ex_mem_alu_result),
      .ex_mem_pc_step   (ex_mem_pc_step),
      .mem_wb_regwrite  (mem_wb_regwrite),
      .mem_wb_rd        (mem_wb_rd),
      .mem_wb_data      (mem_wb_data),
      .flag             (fwd_flag[i]),
      .data             (fwd_data[XLEN*i +: XLEN]),
      .lane_stall       (lane_stall[i])
    );
  end

  always_comb begin
    // In the completion cycle the MC unit is free and the pending write retires,
    // so neither the structural nor the WAW hazard applies.
    struct_hz = id_ex_mc & mc_busy & ~mc_done;
    waw_hz    = id_ex_regwrite & pend_v_q & (id_ex_rd == pend_rd_q) & ~mc_done;
    stall     = id_ex_valid & ((|lane_stall) | struct_hz | waw_hz);
    issue     = id_ex_valid & id_ex_mc & ex_fire & ~stall;
  end

  always_comb begin
    cnt_d     = cnt_q;
    pend_v_d  = pend_v_q;
    pend_rd_d = pend_rd_q;
    if (issue) begin
      // Reload wins over retirement of the op completing this cycle.
      cnt_d     = 4'(MC_LAT);
      pend_v_d  = id_ex_regwrite & (id_ex_rd != '0);
      pend_rd_d = id_ex_rd;
    end else begin
      if (mc_busy) begin
        cnt_d = cnt_q - 4'd1;
      end
      if (mc_done) begin
        pend_v_d  = 1'b0;
        pend_rd_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      pend_v_q  <= 1'b0;
      pend_rd_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_v_q  <= pend_v_d;
      pend_rd_q <= pend_rd_d;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Scoreboard bench: each driven cycle pushes its expected outputs; a negedge process pops
// and compares them against the DUT.
module tb_forwarding_scoreboard;
  import fwd_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NSRC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_ex_valid, id_ex_regwrite, id_ex_mc, ex_fire;
  logic [9:0]       id_ex_rs;
  logic [4:0]       id_ex_rd, ex_mem_rd, mem_wb_rd, mc_pending_rd;
  logic             ex_mem_regwrite, ex_mem_memread, ex_mem_jump, mem_wb_regwrite;
  logic [31:0]      ex_mem_alu_result, ex_mem_pc_step, mem_wb_data, mc_result;
  logic [1:0]       fwd_flag;
  logic [63:0]      fwd_data;
  logic             stall, mc_busy, mc_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [1:0]  flag;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  dchk;
    logic        stall;
    logic        busy;
    logic        done;
    logic [4:0]  prd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  forwarding_scoreboard #(
    .XLEN  (XLEN),
    .NSRC  (NSRC),
    .MC_LAT(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_ex_valid      (id_ex_valid),
    .id_ex_rs         (id_ex_rs),
    .id_ex_rd         (id_ex_rd),
    .id_ex_regwrite   (id_ex_regwrite),
    .id_ex_mc         (id_ex_mc),
    .ex_fire          (ex_fire),
    .ex_mem_regwrite  (ex_mem_regwrite),
    .ex_mem_memread   (ex_mem_memread),
    .ex_mem_jump      (ex_mem_jump),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_pc_step   (ex_mem_pc_step),
    .mem_wb_regwrite  (mem_wb_regwrite),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_data      (mem_wb_data),
    .mc_result        (mc_result),
    .fwd_flag         (fwd_flag),
    .fwd_data         (fwd_data),
    .stall            (stall),
    .mc_busy          (mc_busy),
    .mc_done          (mc_done),
    .mc_pending_rd    (mc_pending_rd)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] flag, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [1:0] dchk, input logic stl,
                      input logic busy, input logic done, input logic [4:0] prd);
    exp_t e;
    e.tag = tag; e.flag = flag; e.d0 = d0; e.d1 = d1; e.dchk = dchk;
    e.stall = stl; e.busy = busy; e.done = done; e.prd = prd;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq({e.tag, ".flag"}, 64'(fwd_flag), 64'(e.flag));
      if (e.dchk[0]) check_eq({e.tag, ".d0"}, 64'(fwd_data[31:0]), 64'(e.d0));
      if (e.dchk[1]) check_eq({e.tag, ".d1"}, 64'(fwd_data[63:32]), 64'(e.d1));
      check_eq({e.tag, ".stall"}, 64'(stall), 64'(e.stall));
      check_eq({e.tag, ".busy"}, 64'(mc_busy), 64'(e.busy));
      check_eq({e.tag, ".done"}, 64'(mc_done), 64'(e.done));
      check_eq({e.tag, ".prd"}, 64'(mc_pending_rd), 64'(e.prd));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    id_ex_valid = 0; id_ex_regwrite = 0; id_ex_mc = 0; ex_fire = 0;
    id_ex_rs = '0; id_ex_rd = '0;
    ex_mem_regwrite = 0; ex_mem_memread = 0; ex_mem_jump = 0; ex_mem_rd = '0;
    ex_mem_alu_result = '0; ex_mem_pc_step = '0;
    mem_wb_regwrite = 0; mem_wb_rd = '0; mem_wb_data = '0; mc_result = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset state
    step();
    push("reset", 2'b00, 32'h0, 32'h0, 2'b11, 0, 0, 0, 5'd0);

    // Both operands forwarded from different stages
    step();
    rst = 1'b0;
    id_ex_valid = 1; id_ex_rs = {5'd6, 5'd5};
    ex_mem_regwrite = 1; ex_mem_rd = 5'd5; ex_mem_alu_result = 32'h1234;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd6; mem_wb_data = 32'hBEEF;
    push("fwd2", 2'b11, 32'h1234, 32'hBEEF, 2'b11, 0, 0, 0, 5'd0);

    // Load-use
    step();
    id_ex_rs = {5'd0, 5'd5}; ex_mem_memread = 1;
    mem_wb_regwrite = 0; mem_wb_data = 32'h55;
    push("loaduse", 2'b00, 32'h0, 32'h55, 2'b10, 1, 0, 0, 5'd0);

    // Same hazard with no valid instruction never stalls
    step();
    id_ex_valid = 0;
    push("loaduse_inv", 2'b00, 32'h0, 32'h55, 2'b10, 0, 0, 0, 5'd0);

    // Load has moved to MEM/WB
    step();
    id_ex_valid = 1;
    ex_mem_regwrite = 0; ex_mem_memread = 0;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd5; mem_wb_data = 32'hAAAA;
    push("load_wb", 2'b01, 32'hAAAA, 32'hAAAA, 2'b11, 0, 0, 0, 5'd0);

    // Jump link value
    step();
    id_ex_rs = {5'd1, 5'd0};
    ex_mem_regwrite = 1; ex_mem_jump = 1; ex_mem_rd = 5'd1;
    ex_mem_pc_step = 32'h104; ex_mem_alu_result = 32'h0;
    mem_wb_regwrite = 0; mem_wb_data = 32'h77;
    push("jump", 2'b10, 32'h77, 32'h104, 2'b11, 0, 0, 0, 5'd0);

    // x0 never forwards
    step();
    id_ex_rs = {5'd0, 5'd0}; ex_mem_rd = 5'd0;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd0;
    push("x0", 2'b00, 32'h77, 32'h77, 2'b11, 0, 0, 0, 5'd0);

    // MC issue rd=7
    step();
    idle_inputs();
    mem_wb_data = 32'h11;
    id_ex_valid = 1; id_ex_mc = 1; id_ex_regwrite = 1; id_ex_rd = 5'd7; ex_fire = 1;
    push("mc_issue", 2'b00, 32'h11, 32'h11, 2'b11, 0, 0, 0, 5'd0);

    // Dependent on rd=7 stalls for three cycles
    step();
    id_ex_mc = 0; id_ex_regwrite = 0; id_ex_rd = 5'd0; ex_fire = 0;
    id_ex_rs = {5'd0, 5'd7};
    push("mc_dep1", 2'b00, 32'h0, 32'h11, 2'b10, 1, 1, 0, 5'd7);
    step();
    push("mc_dep2", 2'b00, 32'h0, 32'h11, 2'b10, 1, 1, 0, 5'd7);
    step();
    push("mc_dep3", 2'b00, 32'h0, 32'h11, 2'b10, 1, 1, 0, 5'd7);
    step();
    mc_result = 32'hCAFE; ex_fire = 1;
    push("mc_done", 2'b01, 32'hCAFE, 32'h11, 2'b11, 0, 1, 1, 5'd7);
    step();
    idle_inputs();
    mem_wb_data = 32'h11;
    push("mc_clear", 2'b00, 32'h11, 32'h11, 2'b11, 0, 0, 0, 5'd0);

    // Back-to-back MC ops: second waits for the completion cycle, then issues in it
    step();
    id_ex_valid = 1; id_ex_mc = 1; id_ex_regwrite = 1; id_ex_rd = 5'd8; ex_fire = 1;
    push("mc2_issue", 2'b00, 32'h11, 32'h11, 2'b11, 0, 0, 0, 5'd0);
    step();
    id_ex_rd = 5'd9;
    push("mc2_struct1", 2'b00, 32'h11, 32'h11, 2'b11, 1, 1, 0, 5'd8);
    step();
    push("mc2_struct2", 2'b00, 32'h11, 32'h11, 2'b11, 1, 1, 0, 5'd8);
    step();
    push("mc2_struct3", 2'b00, 32'h11, 32'h11, 2'b11, 1, 1, 0, 5'd8);
    step();
    push("mc2_reissue", 2'b00, 32'h11, 32'h11, 2'b11, 0, 1, 1, 5'd8);

    // Reloaded with no gap; non-MC write to the pending rd is a WAW stall
    step();
    id_ex_mc = 0; ex_fire = 0;
    push("waw", 2'b00, 32'h11, 32'h11, 2'b11, 1, 1, 0, 5'd9);

    // Reset in cycle 2 of the op discards it; the dependent no longer stalls
    step();
    id_ex_regwrite = 0; id_ex_rd = 5'd0; id_ex_rs = {5'd0, 5'd9};
    rst = 1'b1;
    push("mid_reset", 2'b00, 32'h11, 32'h11, 2'b11, 0, 0, 0, 5'd0);
    step();
    rst = 1'b0;
    push("post_reset", 2'b00, 32'h11, 32'h11, 2'b11, 0, 0, 0, 5'd0);

    @(negedge clk);
    #1;
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised successor to the EX-stage forwarding logic. It adds load-use and multi-cycle-unit (MC) hazard handling via a one-entry scoreboard with a latency counter. It resolves NSRC source operands of the instruction in ID/EX against EX/MEM, MEM/WB and the single in-flight MC result, and produces per-operand forward data plus one pipeline stall. It sits between the ID/EX register and the ALU operand muxes; its stall output gates the ID/EX and IF/ID enables.

## Interface
- XLEN, 32, datapath width
- NSRC, 2, number of source operands resolved per instruction (1..4)
- MC_LAT, 4, cycles from MC issue to MC result valid (2..15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_rs  in  5*NSRC  source register indices; operand i at [5i+4:5i]
- id_ex_rd  in  5  destination of the ID/EX instruction
- id_ex_regwrite  in  1  ID/EX instruction writes rd
- id_ex_mc  in  1  ID/EX instruction executes on the MC unit
- ex_fire  in  1  ID/EX instruction leaves EX this cycle
- ex_mem_regwrite, ex_mem_memread, ex_mem_jump  in  1 each  EX/MEM control
- ex_mem_rd  in  5  EX/MEM destination
- ex_mem_alu_result, ex_mem_pc_step  in  XLEN each  EX/MEM forward candidates
- mem_wb_regwrite  in  1;  mem_wb_rd  in  5;  mem_wb_data  in  XLEN  write-back data
- mc_result  in  XLEN  MC unit output, valid only in the completion cycle
- fwd_flag  out  NSRC  operand i takes fwd_data instead of the register-file value
- fwd_data  out  XLEN*NSRC  forwarded value; operand i at [XLEN*i+XLEN-1:XLEN*i]
- stall  out  1  hold IF/ID and ID/EX; insert bubble into EX/MEM
- mc_busy  out  1  MC unit occupied
- mc_done  out  1  completion cycle (cnt==1); top writes mc_result to register file at pending rd
- mc_pending_rd  out  5  rd of in-flight MC op (0 if none)

## Operation
- State: cnt[3:0], pend_v, pend_rd[4:0]. mc_busy = (cnt!=0). mc_done = (cnt==1).
- Issue: id_ex_valid & id_ex_mc & ex_fire & ~stall. Effects: cnt <= MC_LAT; pend_v <= id_ex_regwrite & (id_ex_rd!=0); pend_rd <= id_ex_rd.
- Countdown: if no issue and cnt!=0, cnt <= cnt-1. On mc_done with no issue, pend_v <= 0 and pend_rd <= 0.
- Per operand i, rs=id_ex_rs[i], considered only if rs!=0. First match wins:
  1. pend_v & pend_rd==rs: forward mc_result if mc_done, else stall.
  2. ex_mem_regwrite & ex_mem_rd==rs: stall if ex_mem_memread (load-use). Otherwise forward ex_mem_pc_step if ex_mem_jump, else ex_mem_alu_result.
  3. mem_wb_regwrite & mem_wb_rd==rs: forward mem_wb_data.
  4. Otherwise: fwd_flag=0, fwd_data=mem_wb_data.
- A lane that stalls drives fwd_flag=0.
- Further stall causes, all gated by id_ex_valid:
  - structural: id_ex_mc & mc_busy & ~mc_done
  - WAW: id_ex_regwrite & pend_v & id_ex_rd==pend_rd & ~mc_done
- stall is the OR of all lane stalls and the causes above. It is 0 whenever id_ex_valid=0.
- ex_fire while stall=1 is ignored for issue.

## Timing
- Reset: cnt=0, pend_v=0, pend_rd=0. Hence mc_busy=0, mc_done=0, mc_pending_rd=0. fwd_flag/stall follow combinationally from inputs with empty scoreboard.
- Forward paths and stall are combinational, with zero latency.
- Issue at edge ending cycle k gives cnt=MC_LAT in cycle k+1 and mc_done in cycle k+MC_LAT. The scoreboard clears at the edge ending that cycle.
- Issue in the mc_done cycle is legal: reload wins, pend takes the new op.
- Reset mid-operation discards the in-flight op. The top flushes the MC unit on the same reset.
- Register file write-first: once pend clears, the value is visible through the normal read path.

## Structure
- Package fwd_pkg: REG_W=5; enum fwd_src_e {SRC_NONE, SRC_MC, SRC_EXMEM, SRC_MEMWB}; lane-select function shared with the bench model.
- Sub-module fwd_lane: one operand's priority compare. It outputs flag, data and lane stall, and is instantiated NSRC times with a generate loop. Scoreboard state stays in the top.

## Test plan
- Reset, rs1=5, rs2=6, EX/MEM rd=5 ALU result 0x1234, MEM/WB rd=6 data 0xBEEF: fwd_flag=2'b11, data 0x1234/0xBEEF, stall=0.
- EX/MEM rd=5 with memread=1, ID/EX rs1=5: stall=1, fwd_flag[0]=0. Next cycle EX/MEM bubble, MEM/WB rd=5: forward mem_wb_data, stall=0.
- EX/MEM jump=1, rd=1, pc_step=0x104, alu_result=0x0, rs2=1: fwd_data lane1=0x104. With rd=0 or rs=0: no forward.
- MC issue rd=7, MC_LAT=4. Dependent rs1=7 stalls for 3 cycles. In cycle 4, mc_done=1, mc_result=0xCAFE, forwarded with stall=0. mc_pending_rd returns to 0 after that edge.
- Second MC op during busy: stall until the mc_done cycle, then issues in the same cycle with cnt reloaded to 4 and no gap. An rd=7 non-MC write during pending stalls (WAW).
- Assert rst in cycle 2 of an MC op: mc_busy=0 and mc_pending_rd=0 immediately, and the dependent instruction no longer stalls.
